bram_led_scanner: RTL

//   Downstream consumer of the 16-bit frame BRAM. Walks BRAM addresses 0..DEPTH-1 in order,

---
 rtl/led_ctrl_pkg.sv | 15 +
 rtl/dwell_timer.sv | 40 ++++
 rtl/bram_led_scanner.sv | 121 ++++++++++++
 3 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared constants for the LED scanner and the frame BRAM it reads.
//   DATA_W  : BRAM word / LED width, fixed by the BRAM.
//   state_t : scanner FSM state encoding (IDLE, FETCH, LATCH, SHOW).
package led_ctrl_pkg;

   localparam int DATA_W = 16;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t FETCH = 2'd1;
   localparam state_t LATCH = 2'd2;
   localparam state_t SHOW  = 2'd3;

endpackage

// File: rtl/dwell_timer.sv
// Dwell counter for the LED scanner. Counts clocks while run=1 and flags
// the last dwell cycle. It wraps to zero on that cycle, so it cannot overflow.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   clear  in  forces the count to zero (takes priority over run)
//   run    in  count this cycle
//   done   out count has reached DWELL_CYCLES-1 (decoded from the count register)
module dwell_timer #(
   parameter int DWELL_CYCLES = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic done
);

   localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign done = (cnt_q == LAST);

endmodule

// File: rtl/bram_led_scanner.sv
// Walks a frame BRAM from address 0 to DEPTH-1. It reads each word over a
// 1-cycle-latency port and holds the word on the LEDs for DWELL_CYCLES clocks.
// It pulses frame_done on the edge that completes the last word's dwell.
// Ports:
//   clk, reset   system clock / asynchronous active-high reset
//   enable       level: run when 1, pause when 0 (FETCH/LATCH always complete)
//   restart      1-cycle request to rewind to address 0 and return to IDLE
//   rd_en        BRAM read enable (high only in FETCH)
//   rd_addr      BRAM read address (always the current word address)
//   rd_data      BRAM read data, valid the cycle after rd_en
//   led          registered LED drive
//   frame_done   1-cycle pulse at the end of each full pass
//   state_dbg    current FSM state, for observation
// Handshake: a read is issued by rd_en=1 for exactly one cycle. rd_data is
// consumed only on the following cycle (LATCH) and is ignored at all other times.
module bram_led_scanner
   import led_ctrl_pkg::*;
#(
   parameter int DEPTH        = 256,
   parameter int ADDR_W       = 8,
   parameter int DWELL_CYCLES = 100_000_000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              restart,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic [DATA_W-1:0] led,
   output logic              frame_done,
   output logic [1:0]        state_dbg
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] led_q, led_d;
   logic              frame_done_q, frame_done_d;
   logic              dwell_done;
   logic              timer_clear;
   logic              timer_run;
   logic              terminal;

   // The dwell ends only on a counting cycle. A paused SHOW never advances.
   assign terminal = (state_q == SHOW) && enable && dwell_done;

   // The counter is held at zero everywhere except SHOW. This gives the
   // "cnt<=0 at LATCH" behaviour, and restart clears it as well.
   assign timer_clear = restart || (state_q != SHOW);
   assign timer_run   = (state_q == SHOW) && enable;

   dwell_timer #(
      .DWELL_CYCLES(DWELL_CYCLES)
   ) u_dwell_timer (
      .clk   (clk),
      .reset (reset),
      .clear (timer_clear),
      .run   (timer_run),
      .done  (dwell_done)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic. FETCH and LATCH ignore enable so that an issued read
   // always lands on the LEDs.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (enable) state_d = FETCH;
         FETCH:   state_d = LATCH;
         LATCH:   state_d = SHOW;
         SHOW:    if (terminal) state_d = FETCH;
         default: state_d = IDLE;
      endcase
      if (restart) state_d = IDLE;
   end

   // Datapath next values: address, LED word and frame pulse
   always_comb begin
      addr_d       = addr_q;
      led_d        = led_q;
      frame_done_d = 1'b0;
      if (restart) begin
         addr_d = '0;
      end else begin
         if (state_q == LATCH) led_d = rd_data;
         if (terminal) begin
            addr_d       = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
            frame_done_d = (addr_q == LAST_ADDR);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_q       <= '0;
         led_q        <= '0;
         frame_done_q <= 1'b0;
      end else begin
         addr_q       <= addr_d;
         led_q        <= led_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Outputs: registers, or decodes of the state register only
   always_comb begin
      rd_en      = (state_q == FETCH);
      rd_addr    = addr_q;
      led        = led_q;
      frame_done = frame_done_q;
      state_dbg  = state_q;
   end

endmodule
